// File: rtl/escalonador_rr.sv
// Round-robin process scheduler: slot table, per-instruction quantum counter and
// context-switch sequencing for the CPU.
module escalonador_rr #(
    parameter int unsigned NUM_PROC        = 8,
    parameter int unsigned PC_WIDTH        = 32,
    parameter int unsigned QUANTUM_WIDTH   = 8,
    parameter int unsigned DEFAULT_QUANTUM = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        passo,
    input  logic [PC_WIDTH-1:0]         pc_proximo,
    input  logic                        criar,
    input  logic [$clog2(NUM_PROC)-1:0] criar_id,
    input  logic [PC_WIDTH-1:0]         criar_pc,
    input  logic                        fim_processo,
    input  logic                        pedido_io,
    input  logic                        io_pronto,
    input  logic [$clog2(NUM_PROC)-1:0] io_id,
    input  logic                        quantum_we,
    input  logic [QUANTUM_WIDTH-1:0]    quantum_valor,
    output logic                        troca_contexto,
    output logic [PC_WIDTH-1:0]         pc_novo,
    output logic [$clog2(NUM_PROC)-1:0] processo_atual,
    output logic                        processo_valido,
    output logic                        ocioso,
    output logic                        erro,
    output logic [QUANTUM_WIDTH-1:0]    quantum_restante
);
    localparam int unsigned ID_W = $clog2(NUM_PROC);

    typedef enum logic [1:0] {S_IDLE, S_PICK, S_RUN} fsm_t;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_READY, SLOT_RUNNING, SLOT_BLOCKED} slot_t;

    fsm_t                     state, state_next;
    slot_t                    slot_st [NUM_PROC];
    logic [PC_WIDTH-1:0]      slot_pc [NUM_PROC];
    logic [QUANTUM_WIDTH-1:0] quantum_cfg;

    logic            any_ready, pick_found;
    logic [ID_W-1:0] pick_id;
    logic            ev_fim, ev_io, ev_any;
    logic            criar_in, io_in;
    logic            criar_ok, criar_err, io_ok, io_err, q_err;

    // Any READY slot in the registered table
    always_comb begin
        any_ready = 1'b0;
        for (int i = 0; i < int'(NUM_PROC); i++) begin
            if (slot_st[i] == SLOT_READY) any_ready = 1'b1;
        end
    end

    // Circular scan starting after the current slot and wrapping back onto it
    always_comb begin
        pick_found = 1'b0;
        pick_id    = processo_atual;
        for (int i = 1; i <= int'(NUM_PROC); i++) begin
            if (!pick_found &&
                slot_st[(int'(processo_atual) + i) % int'(NUM_PROC)] == SLOT_READY) begin
                pick_found = 1'b1;
                pick_id    = ID_W'((int'(processo_atual) + i) % int'(NUM_PROC));
            end
        end
    end

    // Run-time events (fim > io > expiry) and request legality
    always_comb begin
        ev_fim    = (state == S_RUN) && fim_processo;
        ev_io     = (state == S_RUN) && pedido_io && !fim_processo;
        ev_any    = (state == S_RUN) &&
                    (fim_processo || pedido_io ||
                     (passo && quantum_restante == QUANTUM_WIDTH'(1)));
        criar_in  = int'(criar_id) < int'(NUM_PROC);
        io_in     = int'(io_id) < int'(NUM_PROC);
        io_ok     = io_pronto && io_in && (slot_st[io_id] == SLOT_BLOCKED);
        io_err    = io_pronto && !io_ok;
        criar_ok  = criar && criar_in && (slot_st[criar_id] == SLOT_FREE) &&
                    !(io_pronto && io_id == criar_id);
        criar_err = criar && !criar_ok;
        q_err     = quantum_we && (quantum_valor == '0);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_ready) state_next = S_PICK;
            S_PICK:  state_next = pick_found ? S_RUN : S_IDLE;
            S_RUN:   if (ev_any) state_next = S_PICK;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= S_IDLE;
            quantum_cfg      <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
            troca_contexto   <= 1'b0;
            pc_novo          <= '0;
            processo_atual   <= '0;
            processo_valido  <= 1'b0;
            ocioso           <= 1'b1;
            erro             <= 1'b0;
            quantum_restante <= '0;
            for (int i = 0; i < int'(NUM_PROC); i++) begin
                slot_st[i] <= SLOT_FREE;
                slot_pc[i] <= '0;
            end
        end else begin
            state          <= state_next;
            troca_contexto <= 1'b0;
            erro           <= criar_err | io_err | q_err;
            if (quantum_we && !q_err) quantum_cfg <= quantum_valor;

            case (state)
                S_PICK: begin
                    if (pick_found) begin
                        slot_st[pick_id] <= SLOT_RUNNING;
                        processo_atual   <= pick_id;
                        pc_novo          <= slot_pc[pick_id];
                        troca_contexto   <= 1'b1;
                        quantum_restante <= quantum_cfg;
                        processo_valido  <= 1'b1;
                        ocioso           <= 1'b0;
                    end else begin
                        processo_valido  <= 1'b0;
                        ocioso           <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (ev_any) begin
                        processo_valido  <= 1'b0;
                        quantum_restante <= '0;
                        if (ev_fim) begin
                            slot_st[processo_atual] <= SLOT_FREE;
                        end else begin
                            slot_st[processo_atual] <= ev_io ? SLOT_BLOCKED : SLOT_READY;
                            slot_pc[processo_atual] <= pc_proximo;
                        end
                    end else if (passo) begin
                        quantum_restante <= quantum_restante - QUANTUM_WIDTH'(1);
                    end
                end
                default: ;
            endcase

            // Legal requests never target the RUNNING slot, so these cannot collide with the above
            if (io_ok) slot_st[io_id] <= SLOT_READY;
            if (criar_ok) begin
                slot_st[criar_id] <= SLOT_READY;
                slot_pc[criar_id] <= criar_pc;
            end
        end
    end

endmodule

// File: tb/tb_escalonador_rr.sv
// Directed bench for escalonador_rr: expected dispatches and erro pulses are queued
// by the stimulus and consumed by a negedge monitor.
module tb_escalonador_rr;
    logic        clock = 1'b0;
    logic        reset;
    logic        passo;
    logic [31:0] pc_proximo;
    logic        criar;
    logic [2:0]  criar_id;
    logic [31:0] criar_pc;
    logic        fim_processo;
    logic        pedido_io;
    logic        io_pronto;
    logic [2:0]  io_id;
    logic        quantum_we;
    logic [7:0]  quantum_valor;
    logic        troca_contexto;
    logic [31:0] pc_novo;
    logic [2:0]  processo_atual;
    logic        processo_valido;
    logic        ocioso;
    logic        erro;
    logic [7:0]  quantum_restante;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] pc;
        logic [7:0]  q;
    } disp_t;

    disp_t exp_q [$];
    disp_t e;
    int    total = 0;
    int    bad = 0;
    int    err_pending = 0;

    escalonador_rr dut (
        .clock(clock), .reset(reset), .passo(passo), .pc_proximo(pc_proximo),
        .criar(criar), .criar_id(criar_id), .criar_pc(criar_pc),
        .fim_processo(fim_processo), .pedido_io(pedido_io),
        .io_pronto(io_pronto), .io_id(io_id),
        .quantum_we(quantum_we), .quantum_valor(quantum_valor),
        .troca_contexto(troca_contexto), .pc_novo(pc_novo),
        .processo_atual(processo_atual), .processo_valido(processo_valido),
        .ocioso(ocioso), .erro(erro), .quantum_restante(quantum_restante)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        passo = 1'b0; criar = 1'b0; fim_processo = 1'b0; pedido_io = 1'b0;
        io_pronto = 1'b0; quantum_we = 1'b0;
    endtask

    task automatic push_disp(input logic [2:0] id, input logic [31:0] pc, input logic [7:0] q);
        disp_t d;
        d.id = id; d.pc = pc; d.q = q;
        exp_q.push_back(d);
    endtask

    task automatic wait_dispatch(input string name);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Request held one cycle; the resulting erro pulse must be seen by the monitor
    task automatic expect_err(input string name);
        err_pending++;
        tick();
        clear_inputs();
        tick();
        chk(name, 32'(err_pending), 32'd0);
        err_pending = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_troca"},  32'(troca_contexto),   32'd0);
        chk({tag, "_pc"},     pc_novo,               32'd0);
        chk({tag, "_atual"},  32'(processo_atual),   32'd0);
        chk({tag, "_valido"}, 32'(processo_valido),  32'd0);
        chk({tag, "_ocioso"}, 32'(ocioso),           32'd1);
        chk({tag, "_erro"},   32'(erro),             32'd0);
        chk({tag, "_q"},      32'(quantum_restante), 32'd0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clock);
                if (troca_contexto) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_troca", 32'(troca_contexto), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("disp_id",     32'(processo_atual),   32'(e.id));
                        chk("disp_pc",     pc_novo,               e.pc);
                        chk("disp_q",      32'(quantum_restante), 32'(e.q));
                        chk("disp_valido", 32'(processo_valido),  32'd1);
                        chk("disp_ocioso", 32'(ocioso),           32'd0);
                    end
                end
                if (erro) begin
                    if (err_pending > 0) err_pending--;
                    else chk("unexpected_erro", 32'(erro), 32'd0);
                end
            end
        join_none

        reset = 1'b0; pc_proximo = '0; criar_id = '0; criar_pc = '0; io_id = '0;
        quantum_valor = '0;
        clear_inputs();
        tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b1;

        // First dispatch: troca two cycles after criar
        criar = 1'b1; criar_id = 3'd2; criar_pc = 32'd100;
        push_disp(3'd2, 32'd100, 8'd16);
        tick(); clear_inputs();
        tick();
        chk("lat_troca_early", 32'(troca_contexto), 32'd0);
        tick();
        chk("lat_troca", 32'(troca_contexto), 32'd1);
        wait_dispatch("disp_first");

        // Illegal requests leave state and quantum untouched
        criar = 1'b1; criar_id = 3'd2; criar_pc = 32'd999;
        expect_err("err_criar_running");
        io_pronto = 1'b1; io_id = 3'd5;
        expect_err("err_io_free");
        quantum_we = 1'b1; quantum_valor = 8'd0;
        expect_err("err_quantum_zero");
        chk("err_atual",  32'(processo_atual),   32'd2);
        chk("err_valido", 32'(processo_valido),  32'd1);
        chk("err_q",      32'(quantum_restante), 32'd16);

        // End slot 2 while creating slot 1; quantum still default
        fim_processo = 1'b1; criar = 1'b1; criar_id = 3'd1; criar_pc = 32'd20;
        push_disp(3'd1, 32'd20, 8'd16);
        tick(); clear_inputs();
        wait_dispatch("disp_slot1");

        // I/O block with nothing READY -> idle, then wake-up resumes saved PC
        pedido_io = 1'b1; pc_proximo = 32'd55;
        tick(); clear_inputs();
        tick();
        chk("io_ocioso", 32'(ocioso),           32'd1);
        chk("io_valido", 32'(processo_valido),  32'd0);
        chk("io_q",      32'(quantum_restante), 32'd0);
        quantum_we = 1'b1; quantum_valor = 8'd2;
        tick(); clear_inputs();
        io_pronto = 1'b1; io_id = 3'd1;
        push_disp(3'd1, 32'd55, 8'd2);
        tick(); clear_inputs();
        wait_dispatch("disp_io_wake");

        // fim wins over pedido_io and expiry in the same cycle
        criar = 1'b1; criar_id = 3'd6; criar_pc = 32'd60;
        tick(); clear_inputs();
        passo = 1'b1;
        tick(); clear_inputs();
        chk("prio_q_before", 32'(quantum_restante), 32'd1);
        passo = 1'b1; fim_processo = 1'b1; pedido_io = 1'b1; pc_proximo = 32'd77;
        push_disp(3'd6, 32'd60, 8'd2);
        tick(); clear_inputs();
        wait_dispatch("disp_prio");
        io_pronto = 1'b1; io_id = 3'd1;
        expect_err("err_io_slot1_free");

        // Round robin 0 <-> 3 with quantum 3
        criar = 1'b1; criar_id = 3'd0; criar_pc = 32'd10;
        tick();
        criar_id = 3'd3; criar_pc = 32'd40;
        tick(); clear_inputs();
        fim_processo = 1'b1; quantum_we = 1'b1; quantum_valor = 8'd3;
        push_disp(3'd0, 32'd10, 8'd3);
        tick(); clear_inputs();
        wait_dispatch("disp_rr0");
        passo = 1'b1; pc_proximo = 32'd13;
        push_disp(3'd3, 32'd40, 8'd3);
        tick(); tick(); tick(); clear_inputs();
        wait_dispatch("disp_rr3");
        passo = 1'b1; pc_proximo = 32'd43;
        push_disp(3'd0, 32'd13, 8'd3);
        tick(); tick(); tick(); clear_inputs();
        wait_dispatch("disp_rr0_again");

        // Lone process is redispatched with its freshly saved PC
        fim_processo = 1'b1;
        push_disp(3'd3, 32'd43, 8'd3);
        tick(); clear_inputs();
        wait_dispatch("disp_after_fim");
        passo = 1'b1; pc_proximo = 32'd99;
        push_disp(3'd3, 32'd99, 8'd3);
        tick(); tick(); tick(); clear_inputs();
        wait_dispatch("disp_lone");

        // Mid-slice reset
        passo = 1'b1;
        tick(); clear_inputs();
        chk("mid_q", 32'(quantum_restante), 32'd2);
        reset = 1'b0;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b1;
        tick(); tick(); tick();
        chk("post_reset_troca",  32'(troca_contexto),  32'd0);
        chk("post_reset_ocioso", 32'(ocioso),          32'd1);
        chk("post_reset_valido", 32'(processo_valido), 32'd0);
        criar = 1'b1; criar_id = 3'd4; criar_pc = 32'h44;
        push_disp(3'd4, 32'h44, 8'd16);
        tick(); clear_inputs();
        wait_dispatch("disp_post_reset");

        tick(); tick();
        chk("end_exp_q", 32'(exp_q.size()), 32'd0);
        chk("end_err_pending", 32'(err_pending), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
